// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key count, default debounce depth and FSM state encoding.
package keypad_pkg;

  localparam int unsigned N_KEYS             = 10;
  localparam int unsigned DEB_CYCLES_DEFAULT = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE         = 2'd0;
  localparam state_t ST_PRESS_WAIT   = 2'd1;
  localparam state_t ST_HELD         = 2'd2;
  localparam state_t ST_RELEASE_WAIT = 2'd3;

  // True while a committed non-zero vector is being presented.
  function automatic logic state_is_held(input state_t st);
    return (st == ST_HELD) || (st == ST_RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous level inputs, synchronous active-high reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] meta_d;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_debounce_10.sv
// Synchronises and debounces ten key lines as one vector, with press/release event pulses.
// The release pulse port is release_pulse because "release" is a reserved word.
module keypad_debounce_10
  import keypad_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] raw_keys,
  output logic [N_KEYS-1:0] keys,
  output logic              press,
  output logic              release_pulse,
  output logic              held
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

  logic [N_KEYS-1:0] s;

  state_t            state_q, state_d;
  logic [N_KEYS-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_KEYS-1:0] keys_q, keys_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              held_q, held_d;
  logic              cnt_last;

  sync_2ff #(
    .WIDTH(N_KEYS)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (raw_keys),
    .q   (s)
  );

  // The sample that makes the count reach DEB_CYCLES commits; cnt never exceeds DEB_CYCLES-1.
  assign cnt_last = (cnt_q == CNT_W'(DEB_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    keys_d    = keys_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s != '0) begin
          cand_d  = s;
          cnt_d   = CNT_W'(1);
          state_d = ST_PRESS_WAIT;
        end
      end

      ST_PRESS_WAIT: begin
        if (s == cand_q) begin
          if (cnt_last) begin
            keys_d  = cand_q;
            press_d = 1'b1;
            state_d = ST_HELD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (s == '0) begin
          state_d = ST_IDLE;
        end else begin
          cand_d = s;
          cnt_d  = CNT_W'(1);
        end
      end

      ST_HELD: begin
        if (s != keys_q) begin
          cand_d  = s;
          cnt_d   = CNT_W'(1);
          state_d = ST_RELEASE_WAIT;
        end
      end

      ST_RELEASE_WAIT: begin
        // Returning to the committed vector is a glitch, not a new keystroke.
        if (s == keys_q) begin
          state_d = ST_HELD;
        end else if (s == cand_q) begin
          if (cnt_last) begin
            keys_d = cand_q;
            if (cand_q == '0) begin
              release_d = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              press_d = 1'b1;
              state_d = ST_HELD;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cand_d = s;
          cnt_d  = CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    held_d = state_is_held(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      keys_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      keys_q    <= keys_d;
      press_q   <= press_d;
      release_q <= release_d;
      held_q    <= held_d;
    end
  end

  assign keys          = keys_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign held          = held_q;

endmodule

// File: tb/tb_keypad_debounce_10.sv
// Scoreboard bench: a run-length reference model predicts outputs per edge, a monitor compares.
module tb_keypad_debounce_10;

  localparam int DEB = 4;

  typedef struct packed {
    logic [9:0] keys;
    logic       press;
    logic       rel;
    logic       held;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [9:0] raw_keys;
  logic [9:0] keys;
  logic       press;
  logic       release_pulse;
  logic       held;

  int passed;
  int total;

  exp_t exp_q[$];

  keypad_debounce_10 #(
    .DEB_CYCLES(DEB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .raw_keys      (raw_keys),
    .keys          (keys),
    .press         (press),
    .release_pulse (release_pulse),
    .held          (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: keys follows the synchronised stream once a value has been seen
  // DEB times in a row and differs from the current keys.
  logic [9:0] raw_hist[$];
  logic [9:0] run_val;
  logic [9:0] m_keys;
  int         run_len;

  always @(posedge clk) begin
    exp_t       e;
    logic [9:0] s;
    e = '0;
    if (rst) begin
      raw_hist.delete();
      run_val = '0;
      run_len = 0;
      m_keys  = '0;
    end else begin
      s = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 10'h000;
      raw_hist.push_back(raw_keys);
      if (raw_hist.size() > 4) void'(raw_hist.pop_front());
      if (s == run_val) begin
        if (run_len < DEB) run_len++;
      end else begin
        run_val = s;
        run_len = 1;
      end
      if (run_len >= DEB && run_val != m_keys) begin
        m_keys = run_val;
        if (run_val != 10'h000) e.press = 1'b1;
        else e.rel = 1'b1;
      end
    end
    e.keys = m_keys;
    e.held = (m_keys != 10'h000);
    exp_q.push_back(e);
  end

  // Monitor: one expected entry per edge, compared away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("keys", keys, e.keys);
      check("press", {9'b0, press}, {9'b0, e.press});
      check("release", {9'b0, release_pulse}, {9'b0, e.rel});
      check("held", {9'b0, held}, {9'b0, e.held});
    end
  end

  function automatic logic [4:0] encode(input logic [9:0] v);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 0; i < 10; i++) if (v[i]) r = {1'b1, 4'(i)};
    return r;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [9:0] v, input int n);
    raw_keys = v;
    cycles(n);
  endtask

  initial begin
    logic [9:0] v;
    int         sel;
    passed   = 0;
    total    = 0;
    rst      = 1'b1;
    raw_keys = 10'h010;
    @(negedge clk);
    cycles(3);
    rst = 1'b0;
    cycles(10);
    drive(10'h000, 8);

    // Clean press, then the encoder view of keys
    drive(10'h020, 8);
    check("encoder", {5'b0, encode(keys)}, {5'b0, 5'b1_0101});
    drive(10'h000, 8);

    // Bounce
    for (int i = 0; i < 6; i++) drive((i % 2 == 0) ? 10'h020 : 10'h000, 2);
    drive(10'h020, 10);
    drive(10'h000, 8);

    // Release glitch while held
    drive(10'h200, 8);
    drive(10'h000, 2);
    drive(10'h200, 8);
    drive(10'h000, 8);

    // Rollover then release
    drive(10'h002, 8);
    drive(10'h006, 8);
    drive(10'h000, 8);

    // Reset mid-debounce, then restart
    drive(10'h010, 4);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    cycles(10);
    drive(10'h000, 8);

    // Randomised segments
    for (int i = 0; i < 300; i++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       v = 10'h000;
        1:       v = 10'(1 << $urandom_range(0, 9));
        2:       v = raw_keys;
        default: v = 10'($urandom);
      endcase
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        cycles(int'($urandom_range(1, 2)));
        rst = 1'b0;
      end
      drive(v, int'($urandom_range(1, 7)));
    end
    drive(10'h000, 10);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() <= 1) passed++;
    else $display("FAIL drain: got %0d queued expected <=1", exp_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
